wb_dma_hs_ctl: RTL and testbench

WB_DMA_HS_CTL -- requirements
Module: wb_dma_hs_ctl

---
 rtl/wb_dma_hs_pkg.sv | 15 +
 rtl/wb_dma_hs_ch.sv | 109 ++++++++++
 rtl/wb_dma_hs_ctl.sv | 50 +++++
 tb/tb_wb_dma_hs_ctl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dma_hs_pkg.sv
// Shared types and constants for the DMA hardware-handshake controller.
package wb_dma_hs_pkg;

  localparam int CH_NUM_DEF = 31;
  localparam int CH_IDX_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PEND   = 3'd1,
    ST_BUSY   = 3'd2,
    ST_ACK    = 3'd3,
    ST_WAITLO = 3'd4
  } ch_state_e;

endpackage

// File: rtl/wb_dma_hs_ch.sv
// One channel: req/nd synchroniser plus four-phase handshake FSM.
// Synchroniser depth: two flops with WB_DMA_HS_SYNC_EN defined, otherwise one.
module wb_dma_hs_ch
  import wb_dma_hs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic nd_i,
  input  logic ch_en,
  input  logic ch_hs,
  input  logic start,
  input  logic done,
  output logic valid,
  output logic req_s,
  output logic nd_s,
  output logic ack_o,
  output logic busy
);

  ch_state_e state_r;
  ch_state_e state_nxt_s;

`ifdef WB_DMA_HS_SYNC_EN
  logic [1:0] req_sync_r;
  logic [1:0] nd_sync_r;

  // Two-stage synchroniser for the asynchronous peripheral inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_sync_r <= 2'b00;
      nd_sync_r  <= 2'b00;
    end else begin
      req_sync_r <= {req_sync_r[0], req_i};
      nd_sync_r  <= {nd_sync_r[0], nd_i};
    end
  end

  assign req_s = req_sync_r[1];
  assign nd_s  = nd_sync_r[1];
`else
  logic req_sync_r;
  logic nd_sync_r;

  // Single-stage capture of the peripheral inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_sync_r <= 1'b0;
      nd_sync_r  <= 1'b0;
    end else begin
      req_sync_r <= req_i;
      nd_sync_r  <= nd_i;
    end
  end

  assign req_s = req_sync_r;
  assign nd_s  = nd_sync_r;
`endif

  // Next-state logic; software mode pins the FSM in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (!ch_hs) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s && ch_en) state_nxt_s = ST_PEND;
          else                state_nxt_s = ST_IDLE;
        end
        ST_PEND: begin
          if (start)                state_nxt_s = ST_BUSY;
          else if (!req_s || !ch_en) state_nxt_s = ST_IDLE;
          else                      state_nxt_s = ST_PEND;
        end
        ST_BUSY: begin
          if (done) state_nxt_s = ST_ACK;
          else      state_nxt_s = ST_BUSY;
        end
        ST_ACK: begin
          state_nxt_s = ST_WAITLO;
        end
        ST_WAITLO: begin
          if (!req_s) state_nxt_s = ST_IDLE;
          else        state_nxt_s = ST_WAITLO;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register; valid and ack_o are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      valid   <= 1'b0;
      ack_o   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      valid   <= ch_hs ? (state_nxt_s == ST_PEND) : ch_en;
      ack_o   <= (state_nxt_s == ST_ACK);
    end
  end

  assign busy = (state_r == ST_BUSY);

endmodule

// File: rtl/wb_dma_hs_ctl.sv
// DMA hardware-handshake controller: CH_NUM independent channel FSMs.
// Synchroniser depth selected by WB_DMA_HS_SYNC_EN (see wb_dma_hs_ch).
module wb_dma_hs_ctl
  import wb_dma_hs_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH_NUM-1:0]   req_i,
  input  logic [CH_NUM-1:0]   nd_i,
  input  logic [CH_NUM-1:0]   ch_en,
  input  logic [CH_NUM-1:0]   ch_hs,
  input  logic                de_start,
  input  logic [CH_IDX_W-1:0] ch_sel,
  input  logic                de_done,
  output logic [CH_NUM-1:0]   valid,
  output logic [CH_NUM-1:0]   req_s,
  output logic [CH_NUM-1:0]   nd_s,
  output logic [CH_NUM-1:0]   ack_o
);

  logic [CH_NUM-1:0] busy_s;
  logic [CH_NUM-1:0] start_s;
  logic              start_ok_s;

  // A new transfer may begin only if no channel is busy, or the busy one finishes this cycle.
  assign start_ok_s = de_start && ((busy_s == '0) || de_done);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign start_s[i] = start_ok_s && (ch_sel == CH_IDX_W'(i));

    wb_dma_hs_ch u_ch (
      .clk   (clk),
      .rst   (rst),
      .req_i (req_i[i]),
      .nd_i  (nd_i[i]),
      .ch_en (ch_en[i]),
      .ch_hs (ch_hs[i]),
      .start (start_s[i]),
      .done  (de_done),
      .valid (valid[i]),
      .req_s (req_s[i]),
      .nd_s  (nd_s[i]),
      .ack_o (ack_o[i]),
      .busy  (busy_s[i])
    );
  end

endmodule

// File: tb/tb_wb_dma_hs_ctl.sv
// Self-checking bench for wb_dma_hs_ctl: directed scenarios plus randomized run vs a reference model.
module tb_wb_dma_hs_ctl;

  localparam int CH = 31;
`ifdef WB_DMA_HS_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] req_i, nd_i, ch_en, ch_hs;
  logic          de_start, de_done;
  logic [4:0]    ch_sel;
  logic [CH-1:0] valid, req_s, nd_s, ack_o;

  int checks = 0;
  int errors = 0;

  // Reference model: request history, per-channel pending/ack/wait-low flags, index of busy channel.
  logic [CH-1:0] m_req_h [2];
  logic [CH-1:0] m_nd_h  [2];
  logic [CH-1:0] m_pend, m_ack, m_wait, m_valid;
  int            m_busy;

  always #5 clk = ~clk;

  wb_dma_hs_ctl #(.CH_NUM(CH)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .nd_i(nd_i), .ch_en(ch_en), .ch_hs(ch_hs),
    .de_start(de_start), .ch_sel(ch_sel), .de_done(de_done),
    .valid(valid), .req_s(req_s), .nd_s(nd_s), .ack_o(ack_o)
  );

  function automatic logic [CH-1:0] m_req_s();
    return (LAT == 2) ? m_req_h[1] : m_req_h[0];
  endfunction

  function automatic logic [CH-1:0] m_nd_s();
    return (LAT == 2) ? m_nd_h[1] : m_nd_h[0];
  endfunction

  task automatic model_reset();
    m_req_h[0] = '0; m_req_h[1] = '0;
    m_nd_h[0]  = '0; m_nd_h[1]  = '0;
    m_pend = '0; m_ack = '0; m_wait = '0; m_valid = '0;
    m_busy = -1;
  endtask

  task automatic model_step();
    logic [CH-1:0] rs, np, na, nw, nv;
    int  nb;
    bit  start_ok;
    if (!rst) begin
      model_reset();
      return;
    end
    rs = m_req_s();
    np = '0; na = '0; nw = '0; nv = '0; nb = -1;
    start_ok = de_start && (m_busy < 0 || de_done) && (int'(ch_sel) < CH);
    for (int i = 0; i < CH; i++) begin
      if (!ch_hs[i]) begin
        nv[i] = ch_en[i];
      end else begin
        if (m_ack[i]) nw[i] = 1'b1;
        else if (m_wait[i]) nw[i] = rs[i];
        else if (m_busy == i) begin
          if (de_done) na[i] = 1'b1;
          else nb = i;
        end else if (m_pend[i]) begin
          if (start_ok && int'(ch_sel) == i) nb = i;
          else if (rs[i] && ch_en[i]) np[i] = 1'b1;
        end else if (rs[i] && ch_en[i]) np[i] = 1'b1;
        nv[i] = np[i];
      end
    end
    m_req_h[1] = m_req_h[0]; m_req_h[0] = req_i;
    m_nd_h[1]  = m_nd_h[0];  m_nd_h[0]  = nd_i;
    m_pend = np; m_ack = na; m_wait = nw; m_valid = nv; m_busy = nb;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic clear_inputs();
    req_i = '0; nd_i = '0; ch_en = '0; ch_hs = '0;
    de_start = 1'b0; de_done = 1'b0; ch_sel = 5'd0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    checks++; if (valid !== '0) begin errors++; $display("FAIL reset_valid actual=%h expected=0", valid); end
    checks++; if (ack_o !== '0) begin errors++; $display("FAIL reset_ack actual=%h expected=0", ack_o); end
    checks++; if (req_s !== '0) begin errors++; $display("FAIL reset_req_s actual=%h expected=0", req_s); end
    checks++; if (nd_s  !== '0) begin errors++; $display("FAIL reset_nd_s actual=%h expected=0", nd_s); end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL idle_valid actual=%h expected=0", valid); end
  endtask

  task automatic test_basic();
    apply_reset();
    ch_hs[3] = 1'b1; ch_en[3] = 1'b1; req_i[3] = 1'b1;
    for (int e = 1; e <= LAT + 1; e++) begin
      tick();
      checks++;
      if (valid[3] !== (e == LAT + 1)) begin
        errors++; $display("FAIL basic_valid_edge%0d actual=%b expected=%b", e, valid[3], (e == LAT + 1));
      end
    end
    checks++; if (req_s[3] !== 1'b1) begin errors++; $display("FAIL basic_req_s actual=%b expected=1", req_s[3]); end
    de_start = 1'b1; ch_sel = 5'd3;
    tick();
    de_start = 1'b0;
    checks++; if (valid[3] !== 1'b0) begin errors++; $display("FAIL basic_valid_after_start actual=%b expected=0", valid[3]); end
    tick();
    checks++; if (ack_o !== '0) begin errors++; $display("FAIL basic_ack_early actual=%h expected=0", ack_o); end
    de_done = 1'b1;
    tick();
    de_done = 1'b0;
    checks++; if (ack_o !== (CH'(1) << 3)) begin errors++; $display("FAIL basic_ack_pulse actual=%h expected=%h", ack_o, CH'(1) << 3); end
    tick();
    checks++; if (ack_o !== '0) begin errors++; $display("FAIL basic_ack_one_cycle actual=%h expected=0", ack_o); end
    req_i[3] = 1'b0;
    repeat (LAT + 2) tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL basic_idle_valid actual=%h expected=0", valid); end
    checks++; if (m_wait[3] !== 1'b0 || m_pend[3] !== 1'b0) begin errors++; $display("FAIL basic_model_idle actual=%b%b expected=00", m_wait[3], m_pend[3]); end
  endtask

  task automatic test_reack();
    bit seen;
    apply_reset();
    ch_hs[5] = 1'b1; ch_en[5] = 1'b1; req_i[5] = 1'b1;
    repeat (LAT + 1) tick();
    checks++; if (valid[5] !== 1'b1) begin errors++; $display("FAIL reack_first_valid actual=%b expected=1", valid[5]); end
    de_start = 1'b1; ch_sel = 5'd5; tick(); de_start = 1'b0;
    de_done = 1'b1; tick(); de_done = 1'b0;
    checks++; if (ack_o[5] !== 1'b1) begin errors++; $display("FAIL reack_ack actual=%b expected=1", ack_o[5]); end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (valid[5] !== 1'b0) begin errors++; $display("FAIL reack_held_high cycle=%0d actual=%b expected=0", c, valid[5]); end
    end
    req_i[5] = 1'b0;
    repeat (LAT + 2) tick();
    req_i[5] = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      tick();
      if (valid[5] === 1'b1) begin
        seen = 1'b1;
        checks++; if (c != LAT + 1) begin errors++; $display("FAIL reack_second_latency actual=%0d expected=%0d", c, LAT + 1); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL reack_second_valid actual=0 expected=1 (timeout)"); end
  endtask

  task automatic test_en_clear();
    apply_reset();
    ch_hs[2] = 1'b1; ch_en[2] = 1'b1; req_i[2] = 1'b1;
    repeat (LAT + 1) tick();
    checks++; if (valid[2] !== 1'b1) begin errors++; $display("FAIL en_pend_valid actual=%b expected=1", valid[2]); end
    ch_en[2] = 1'b0;
    tick();
    checks++; if (valid[2] !== 1'b0) begin errors++; $display("FAIL en_clear_pend_valid actual=%b expected=0", valid[2]); end
    de_start = 1'b1; ch_sel = 5'd2; tick(); de_start = 1'b0;
    de_done = 1'b1; tick(); de_done = 1'b0;
    checks++; if (ack_o[2] !== 1'b0) begin errors++; $display("FAIL en_clear_no_ack actual=%b expected=0", ack_o[2]); end
    ch_en[2] = 1'b1;
    tick();
    checks++; if (valid[2] !== 1'b1) begin errors++; $display("FAIL en_repend_valid actual=%b expected=1", valid[2]); end
    de_start = 1'b1; ch_sel = 5'd2; tick(); de_start = 1'b0;
    ch_en[2] = 1'b0;
    repeat (2) tick();
    de_done = 1'b1; tick(); de_done = 1'b0;
    checks++; if (ack_o[2] !== 1'b1) begin errors++; $display("FAIL en_clear_busy_ack actual=%b expected=1", ack_o[2]); end
  endtask

  task automatic test_sw_mode();
    apply_reset();
    ch_en[0] = 1'b1; req_i[0] = 1'b1;
    tick();
    checks++; if (valid[0] !== 1'b1) begin errors++; $display("FAIL sw_valid actual=%b expected=1", valid[0]); end
    for (int c = 0; c < 6; c++) begin
      de_start = c[0]; de_done = ~c[0]; ch_sel = 5'd0;
      tick();
      checks++; if (ack_o !== '0) begin errors++; $display("FAIL sw_no_ack cycle=%0d actual=%h expected=0", c, ack_o); end
    end
    de_start = 1'b0; de_done = 1'b0;
    ch_en[0] = 1'b0;
    tick();
    checks++; if (valid[0] !== 1'b0) begin errors++; $display("FAIL sw_valid_follow actual=%b expected=0", valid[0]); end
    ch_hs[4] = 1'b1; ch_en[4] = 1'b1; req_i[4] = 1'b1;
    repeat (LAT + 1) tick();
    de_start = 1'b1; ch_sel = 5'd31; tick(); de_start = 1'b0;
    checks++; if (valid[4] !== 1'b1) begin errors++; $display("FAIL sel31_ignored actual=%b expected=1", valid[4]); end
    de_done = 1'b1; tick(); de_done = 1'b0;
    checks++; if (ack_o !== '0) begin errors++; $display("FAIL sel31_no_ack actual=%h expected=0", ack_o); end
  endtask

  task automatic test_reset_busy();
    apply_reset();
    ch_hs[7] = 1'b1; ch_en[7] = 1'b1; req_i[7] = 1'b1; nd_i = '1;
    repeat (LAT + 1) tick();
    de_start = 1'b1; ch_sel = 5'd7; tick(); de_start = 1'b0;
    checks++; if (valid[7] !== 1'b0) begin errors++; $display("FAIL rb_busy_valid actual=%b expected=0", valid[7]); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (valid !== '0) begin errors++; $display("FAIL rb_async_valid actual=%h expected=0", valid); end
    checks++; if (ack_o !== '0) begin errors++; $display("FAIL rb_async_ack actual=%h expected=0", ack_o); end
    checks++; if (req_s !== '0 || nd_s !== '0) begin errors++; $display("FAIL rb_async_sync actual=%h/%h expected=0/0", req_s, nd_s); end
    tick();
    rst = 1'b1;
    de_done = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (ack_o[7] !== 1'b0) begin errors++; $display("FAIL rb_no_ack cycle=%0d actual=%b expected=0", c, ack_o[7]); end
    end
    de_done = 1'b0;
  endtask

  task automatic test_random();
    int k, sel;
    bit found;
    apply_reset();
    ch_hs = CH'($urandom | $urandom | $urandom);
    ch_en = CH'($urandom | $urandom);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < CH; b++) if ($urandom_range(0, 15) == 0) req_i[b] = ~req_i[b];
      nd_i = CH'($urandom);
      if ($urandom_range(0, 31) == 0) begin k = $urandom_range(0, CH - 1); ch_en[k] = ~ch_en[k]; end
      if ($urandom_range(0, 63) == 0) begin k = $urandom_range(0, CH - 1); ch_hs[k] = ~ch_hs[k]; end
      de_start = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) begin
        found = 1'b0;
        for (int j = 0; j < CH; j++) begin
          if (!found && m_pend[(sel + j) % CH]) begin found = 1'b1; k = (sel + j) % CH; end
        end
        if (found) sel = k;
      end
      ch_sel = 5'(sel);
      de_done = (m_busy >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      tick();
      checks++; if (valid !== m_valid) begin errors++; $display("FAIL rand_valid cycle=%0d actual=%h expected=%h", c, valid, m_valid); end
      checks++; if (ack_o !== m_ack) begin errors++; $display("FAIL rand_ack cycle=%0d actual=%h expected=%h", c, ack_o, m_ack); end
      checks++; if (req_s !== m_req_s()) begin errors++; $display("FAIL rand_req_s cycle=%0d actual=%h expected=%h", c, req_s, m_req_s()); end
      checks++; if (nd_s !== m_nd_s()) begin errors++; $display("FAIL rand_nd_s cycle=%0d actual=%h expected=%h", c, nd_s, m_nd_s()); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reack();
    test_en_clear();
    test_sw_mode();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
